// File: rtl/amm_arb_pkg.sv
// Shared types, constants and the round-robin pick function for amm_rr_arbiter.
package amm_arb_pkg;

    localparam int unsigned ARB_MAX_MASTERS = 8;
    localparam int unsigned ARB_IDX_W       = 3;

    localparam logic [31:0] ARB_TIMEOUT_RDATA = 32'hDEAD_BEEF;

    typedef enum logic {
        ARB_IDLE,
        ARB_BUSY
    } arb_state_t;

    // First set bit of req at or after ptr, walking cyclically over n entries.
    // Returns ptr when nothing is requesting.
    function automatic logic [ARB_IDX_W-1:0] rr_pick(
        input logic [ARB_MAX_MASTERS-1:0] req,
        input logic [ARB_IDX_W-1:0]       ptr,
        input int unsigned                n
    );
        logic [ARB_IDX_W-1:0] idx;
        logic                 found;
        int unsigned          cand;
        idx   = ptr;
        found = 1'b0;
        for (int unsigned k = 0; k < ARB_MAX_MASTERS; k++) begin
            cand = 32'(ptr) + k;
            if (cand >= n) begin
                cand = cand - n;
            end
            if ((k < n) && !found && req[ARB_IDX_W'(cand)]) begin
                idx   = ARB_IDX_W'(cand);
                found = 1'b1;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_grant.sv
// Combinational round-robin priority pick: first requester at or after ptr.
module rr_grant
    import amm_arb_pkg::*;
#(
    parameter int unsigned N_MASTERS = 2,
    parameter int unsigned GW        = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1
) (
    input  logic [N_MASTERS-1:0] req,
    input  logic [GW-1:0]        ptr,
    output logic [GW-1:0]        idx,
    output logic                 any
);

    logic [ARB_MAX_MASTERS-1:0] req_ext;
    logic [ARB_IDX_W-1:0]       ptr_ext;

    always_comb begin
        req_ext = ARB_MAX_MASTERS'(req);
        ptr_ext = ARB_IDX_W'(ptr);
        idx     = GW'(rr_pick(req_ext, ptr_ext, N_MASTERS));
        any     = |req;
    end

endmodule

// File: rtl/amm_rr_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM slave among N_MASTERS masters.
// Optional BUSY watchdog enabled by defining AMM_ARB_TIMEOUT_EN.
module amm_rr_arbiter
    import amm_arb_pkg::*;
#(
    parameter int unsigned N_MASTERS      = 2,
    parameter int unsigned AW             = 32,
    parameter int unsigned DW             = 32,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                          aclk,
    input  logic                          aresetn,
    input  logic [N_MASTERS*AW-1:0]       m_address,
    input  logic [N_MASTERS*DW-1:0]       m_writedata,
    input  logic [N_MASTERS*(DW/8)-1:0]   m_byteenable,
    input  logic [N_MASTERS-1:0]          m_write,
    input  logic [N_MASTERS-1:0]          m_read,
    output logic [DW-1:0]                 m_readdata,
    output logic [N_MASTERS-1:0]          m_waitrequest,
    output logic [AW-1:0]                 s_address,
    output logic [DW-1:0]                 s_writedata,
    output logic [DW/8-1:0]               s_byteenable,
    output logic                          s_write,
    output logic                          s_read,
    input  logic [DW-1:0]                 s_readdata,
    input  logic                          s_waitrequest,
    output logic                          timeout_err
);

    localparam int unsigned GW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
    localparam int unsigned BW = DW / 8;

    if ((N_MASTERS < 2) || (N_MASTERS > ARB_MAX_MASTERS) || (TIMEOUT_CYCLES < 2)) begin : g_param_chk
        $error("amm_rr_arbiter: N_MASTERS must be 2..8 and TIMEOUT_CYCLES >= 2");
    end

    arb_state_t      state_q, state_d;
    logic [GW-1:0]   gnt_q, gnt_d;
    logic [GW-1:0]   ptr_q, ptr_d;
    logic [GW-1:0]   pick_idx;
    logic            pick_any;
    logic            gnt_req;
    logic            busy;
    logic            timeout_hit;
    logic [DW-1:0]   timeout_rdata;
    logic [N_MASTERS-1:0] req;

    assign req  = m_read | m_write;
    assign busy = (state_q == ARB_BUSY);

    rr_grant #(
        .N_MASTERS (N_MASTERS),
        .GW        (GW)
    ) u_rr_grant (
        .req (req),
        .ptr (ptr_q),
        .idx (pick_idx),
        .any (pick_any)
    );

`ifdef AMM_ARB_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES) + 1;

    logic [TW-1:0] timer_q, timer_d;

    // Timer sits at zero in IDLE so it starts from zero on every BUSY entry.
    always_comb begin
        timer_d     = '0;
        timeout_hit = 1'b0;
        if (busy) begin
            timer_d     = timer_q + TW'(1);
            timeout_hit = s_waitrequest && (timer_q == TW'(TIMEOUT_CYCLES - 1));
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // Arbitration and completion sequencing.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        ptr_d   = ptr_q;
        gnt_req = req[gnt_q];
        case (state_q)
            ARB_IDLE: begin
                if (pick_any) begin
                    gnt_d   = pick_idx;
                    state_d = ARB_BUSY;
                end
            end
            ARB_BUSY: begin
                // A dropped request is treated as completion so the bus never wedges.
                if (!s_waitrequest || !gnt_req || timeout_hit) begin
                    ptr_d   = (gnt_q == GW'(N_MASTERS - 1)) ? '0 : gnt_q + GW'(1);
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q <= ARB_IDLE;
            gnt_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        for (int unsigned b = 0; b < DW; b++) begin
            timeout_rdata[b] = ARB_TIMEOUT_RDATA[b % 32];
        end
    end

    // Slave command muxed from the registered grant; only BUSY drives read/write.
    always_comb begin
        s_address     = m_address[32'(gnt_q) * AW +: AW];
        s_writedata   = m_writedata[32'(gnt_q) * DW +: DW];
        s_byteenable  = m_byteenable[32'(gnt_q) * BW +: BW];
        s_write       = busy & m_write[gnt_q];
        s_read        = busy & m_read[gnt_q];
        m_waitrequest = '1;
        if (busy) begin
            m_waitrequest[gnt_q] = s_waitrequest & ~timeout_hit;
        end
        m_readdata    = timeout_hit ? timeout_rdata : s_readdata;
        timeout_err   = timeout_hit;
    end

endmodule

// File: tb/tb_amm_rr_arbiter.sv
// Scoreboard bench for amm_rr_arbiter with three masters and a stallable slave model.
module tb_amm_rr_arbiter;

    localparam int unsigned N  = 3;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned BW = DW / 8;

    logic              aclk = 1'b0;
    logic              aresetn;
    logic [N*AW-1:0]   m_address;
    logic [N*DW-1:0]   m_writedata;
    logic [N*BW-1:0]   m_byteenable;
    logic [N-1:0]      m_write;
    logic [N-1:0]      m_read;
    logic [DW-1:0]     m_readdata;
    logic [N-1:0]      m_waitrequest;
    logic [AW-1:0]     s_address;
    logic [DW-1:0]     s_writedata;
    logic [BW-1:0]     s_byteenable;
    logic              s_write;
    logic              s_read;
    logic [DW-1:0]     s_readdata;
    logic              s_waitrequest;
    logic              timeout_err;

    always #5 aclk = ~aclk;

    amm_rr_arbiter #(
        .N_MASTERS      (N),
        .AW             (AW),
        .DW             (DW),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .m_address     (m_address),
        .m_writedata   (m_writedata),
        .m_byteenable  (m_byteenable),
        .m_write       (m_write),
        .m_read        (m_read),
        .m_readdata    (m_readdata),
        .m_waitrequest (m_waitrequest),
        .s_address     (s_address),
        .s_writedata   (s_writedata),
        .s_byteenable  (s_byteenable),
        .s_write       (s_write),
        .s_read        (s_read),
        .s_readdata    (s_readdata),
        .s_waitrequest (s_waitrequest),
        .timeout_err   (timeout_err)
    );

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
    } cmd_t;

    typedef struct {
        int unsigned mst;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic        to;
    } exp_t;

    cmd_t mq[N][$];
    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   stall_left = 0;

    // Slave model: read data is address + 0x1000_0000, stalls while stall_left > 0.
    assign s_readdata    = s_address + 32'h1000_0000;
    assign s_waitrequest = (stall_left != 0);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_cmd(input int unsigned i, input logic wr, input logic [31:0] addr,
                            input logic [31:0] wdata);
        cmd_t c;
        c.wr = wr; c.addr = addr; c.wdata = wdata;
        mq[i].push_back(c);
    endtask

    task automatic push_exp(input int unsigned i, input logic wr, input logic [31:0] addr,
                            input logic [31:0] data, input logic to);
        exp_t e;
        e.mst = i; e.wr = wr; e.addr = addr; e.data = data; e.to = to;
        sb.push_back(e);
    endtask

    // Master driver and slave stall counter: sample at negedge, act just after posedge.
    logic         rst_s;
    logic [N-1:0] wr_s;
    logic         cmd_s;
    logic [N-1:0] active;

    initial begin : drv
        m_read = '0; m_write = '0; m_address = '0; m_writedata = '0; m_byteenable = '0;
        active = '0;
        forever begin
            @(negedge aclk);
            rst_s = !aresetn;
            wr_s  = m_waitrequest;
            cmd_s = s_read | s_write;
            @(posedge aclk);
            #1;
            if (rst_s) begin
                active = '0; m_read = '0; m_write = '0; stall_left = 0;
                for (int i = 0; i < N; i++) mq[i].delete();
            end else begin
                if (cmd_s && stall_left > 0) stall_left--;
                for (int i = 0; i < N; i++) begin
                    cmd_t c;
                    if (active[i] && !wr_s[i]) begin
                        active[i] = 1'b0; m_read[i] = 1'b0; m_write[i] = 1'b0;
                    end
                    if (!active[i] && mq[i].size() > 0) begin
                        c = mq[i].pop_front();
                        active[i] = 1'b1;
                        m_read[i]  = !c.wr;
                        m_write[i] = c.wr;
                        m_address[i*AW +: AW]    = c.addr;
                        m_writedata[i*DW +: DW]  = c.wdata;
                        m_byteenable[i*BW +: BW] = ~c.addr[3:0];
                    end
                end
            end
        end
    end

    // Monitor: every master-side completion pops and checks one scoreboard entry.
    int          mon_nlow;
    int unsigned mon_who;
    exp_t        mon_e;
    logic [3:0]  mon_be;

    always @(negedge aclk) begin
        if (aresetn) begin
            mon_nlow = 0;
            mon_who  = 0;
            for (int i = 0; i < N; i++) begin
                if (!m_waitrequest[i]) begin
                    mon_nlow++;
                    mon_who = i;
                end
            end
            if (mon_nlow > 0) begin
                chk("one_hot_ack", 32'(mon_nlow), 32'd1);
                if (sb.size() == 0) begin
                    chk("unexpected_ack", 32'(mon_who), 32'hFFFF_FFFF);
                end else begin
                    mon_e  = sb.pop_front();
                    mon_be = ~mon_e.addr[3:0];
                    chk("grant_idx", 32'(mon_who), 32'(mon_e.mst));
                    chk("cmd_type", {30'b0, s_write, s_read}, mon_e.wr ? 32'd2 : 32'd1);
                    chk("s_address", s_address, mon_e.addr);
                    chk("s_byteenable", 32'(s_byteenable), 32'(mon_be));
                    if (mon_e.wr) chk("s_writedata", s_writedata, mon_e.data);
                    else          chk("m_readdata", m_readdata, mon_e.data);
                    chk("timeout_err", 32'(timeout_err), 32'(mon_e.to));
                end
            end
        end
    end

    task automatic do_reset();
        @(posedge aclk); #1;
        aresetn = 1'b0;
        repeat (2) @(posedge aclk);
        #1;
        aresetn = 1'b1;
        @(posedge aclk); #2;
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge aclk);
            n++;
        end
        chk("drain", 32'(sb.size()), 32'd0);
        @(posedge aclk); #2;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int n;
        aresetn = 1'b0;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        chk("rst_waitreq", 32'(m_waitrequest), 32'h7);
        chk("rst_s_cmd", {30'b0, s_write, s_read}, 32'd0);
        chk("rst_timeout_err", 32'(timeout_err), 32'd0);
        @(posedge aclk); #1;
        aresetn = 1'b1;
        @(posedge aclk); #2;

        // 1: single zero-wait read, 2-cycle latency
        push_cmd(0, 1'b0, 32'h0000_0100, 32'h0);
        push_exp(0, 1'b0, 32'h0000_0100, 32'h1000_0100, 1'b0);
        @(posedge aclk);
        @(negedge aclk);
        chk("t1_arb_cycle_s_read", 32'(s_read), 32'd0);
        chk("t1_arb_cycle_waitreq", 32'(m_waitrequest), 32'h7);
        @(negedge aclk);
        chk("t1_busy_s_read", 32'(s_read), 32'd1);
        chk("t1_busy_waitreq0", 32'(m_waitrequest[0]), 32'd0);
        wait_drain(50);

        // 2: m0 and m1 write together from ptr=0, one IDLE cycle between grants
        do_reset();
        push_cmd(0, 1'b1, 32'h0000_0200, 32'h1111_2222);
        push_cmd(1, 1'b1, 32'h0000_0204, 32'h3333_4444);
        push_exp(0, 1'b1, 32'h0000_0200, 32'h1111_2222, 1'b0);
        push_exp(1, 1'b1, 32'h0000_0204, 32'h3333_4444, 1'b0);
        n = 0;
        while (m_waitrequest[0] && n < 20) begin
            @(negedge aclk);
            n++;
        end
        chk("t2_m0_served", 32'(m_waitrequest[0]), 32'd0);
        chk("t2_m1_held", 32'(m_waitrequest[1]), 32'd1);
        @(negedge aclk);
        chk("t2_idle_gap_waitreq", 32'(m_waitrequest), 32'h7);
        chk("t2_idle_gap_s_write", 32'(s_write), 32'd0);
        @(negedge aclk);
        chk("t2_m1_served", 32'(m_waitrequest[1]), 32'd0);
        wait_drain(50);

        // 3: fairness, all three requesting continuously for nine transfers
        do_reset();
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < N; i++) begin
                push_cmd(i, 1'b0, 32'h0000_0400 + 32'(i * 16 + k * 4), 32'h0);
                push_exp(i, 1'b0, 32'h0000_0400 + 32'(i * 16 + k * 4),
                         32'h1000_0400 + 32'(i * 16 + k * 4), 1'b0);
            end
        end
        wait_drain(200);

        // 4: m1 write stalled 5 cycles while m0 waits
        stall_left = 5;
        push_cmd(1, 1'b1, 32'h0000_0204, 32'hA5A5_0001);
        push_exp(1, 1'b1, 32'h0000_0204, 32'hA5A5_0001, 1'b0);
        push_exp(0, 1'b0, 32'h0000_0208, 32'h1000_0208, 1'b0);
        @(posedge aclk);
        @(posedge aclk); #2;
        push_cmd(0, 1'b0, 32'h0000_0208, 32'h0);
        n = 0;
        while (!s_write && n < 20) begin
            @(negedge aclk);
            n++;
        end
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge aclk);
            chk("t4_stall_waitreq", 32'(s_waitrequest), 32'd1);
            chk("t4_stable_addr", s_address, 32'h0000_0204);
            chk("t4_stable_wdata", s_writedata, 32'hA5A5_0001);
            chk("t4_m0_blocked", 32'(m_waitrequest[0]), 32'd1);
        end
        wait_drain(50);

        // 5: reset mid-BUSY aborts the transfer and restores ptr=0
        stall_left = 10;
        push_cmd(1, 1'b0, 32'h0000_030C, 32'h0);
        n = 0;
        while (!s_read && n < 20) begin
            @(negedge aclk);
            n++;
        end
        chk("t5_busy_before_reset", 32'(s_read), 32'd1);
        @(posedge aclk); #1;
        aresetn = 1'b0;
        @(posedge aclk);
        @(negedge aclk);
        chk("t5_abort_s_cmd", {30'b0, s_write, s_read}, 32'd0);
        chk("t5_abort_waitreq", 32'(m_waitrequest), 32'h7);
        @(posedge aclk); #1;
        aresetn = 1'b1;
        @(posedge aclk); #2;
        push_cmd(2, 1'b0, 32'h0000_0500, 32'h0);
        push_cmd(0, 1'b0, 32'h0000_0504, 32'h0);
        push_exp(0, 1'b0, 32'h0000_0504, 32'h1000_0504, 1'b0);
        push_exp(2, 1'b0, 32'h0000_0500, 32'h1000_0500, 1'b0);
        wait_drain(50);

        // 6: slave stuck in waitrequest on an m0 read
        stall_left = 1000;
        push_cmd(0, 1'b0, 32'h0000_0600, 32'h0);
`ifdef AMM_ARB_TIMEOUT_EN
        push_exp(0, 1'b0, 32'h0000_0600, 32'hDEAD_BEEF, 1'b1);
`endif
        n = 0;
        while (!s_read && n < 20) begin
            @(negedge aclk);
            n++;
        end
        chk("t6_busy", 32'(s_read), 32'd1);
`ifdef AMM_ARB_TIMEOUT_EN
        n = 1;
        while (m_waitrequest[0] && n < 100) begin
            @(negedge aclk);
            n++;
        end
        chk("t6_timeout_cycle", 32'(n), 32'd16);
        chk("t6_timeout_pulse", 32'(timeout_err), 32'd1);
        chk("t6_timeout_rdata", m_readdata, 32'hDEAD_BEEF);
        @(negedge aclk);
        chk("t6_pulse_end", 32'(timeout_err), 32'd0);
        stall_left = 0;
        wait_drain(20);
`else
        for (int k = 0; k < 40; k++) begin
            @(negedge aclk);
            chk("t6_stalled", {30'b0, m_waitrequest[0], timeout_err}, 32'd2);
        end
        do_reset();
        wait_drain(20);
`endif

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
